// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if: display, host, clear and RAM-side signals of the text RAM arbiter
interface text_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  modport slave (
    input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, clr_start, ram_dout,
    output disp_valid, disp_data, host_ready, host_rvalid, host_rdata, clr_busy, ram_addr, ram_din, ram_we
  );
  modport master (
    output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, clr_start, ram_dout,
    input  disp_valid, disp_data, host_ready, host_rvalid, host_rdata, clr_busy, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port character RAM between display fetch, clear engine and host (that priority)
module text_ram_arbiter #(
  parameter int              ADDR_W    = 10,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic            clk,
  input logic            reset,
  text_ram_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              host_xfer;
  logic              clr_wr;
  always_comb begin
    bus.host_ready = reset & (state == IDLE) & ~bus.disp_req & ~bus.clr_start;
    host_xfer      = bus.host_valid & bus.host_ready;
    clr_wr         = (state == CLEAR) & ~bus.disp_req;
    bus.ram_addr   = bus.disp_req ? bus.disp_addr : clr_wr ? clr_cnt : host_xfer ? bus.host_addr : bus.disp_addr;
    bus.ram_din    = clr_wr ? CLEAR_VAL : bus.host_wdata;
    bus.ram_we     = reset & (clr_wr | (host_xfer & bus.host_we));
    bus.disp_data  = bus.ram_dout;
    bus.host_rdata = bus.ram_dout;
    bus.clr_busy   = (state == CLEAR);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      clr_cnt         <= '0;
      bus.disp_valid  <= 1'b0;
      bus.host_rvalid <= 1'b0;
    end else begin
      bus.disp_valid  <= bus.disp_req;
      bus.host_rvalid <= host_xfer & ~bus.host_we;
      if (state == IDLE && bus.clr_start) begin
        state   <= CLEAR;
        clr_cnt <= '0;
      end else if (clr_wr) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) state <= IDLE;
      end
    end
  end
endmodule
